// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: circular FIFO feeding a UART serializer (start, NB_DATA data bits LSB first, optional even parity, stop).
//   Ports: clk      - rising-edge clock
//          reset    - asynchronous active-low reset
//          s_tick   - 16x oversampled baud tick, one clk wide
//          wr_tx    - write strobe, accepted only while tx_full is low
//          data_tx  - word written on wr_tx
//          tx_full  - FIFO full (registered)
//          tx_busy  - serializer active or FIFO non-empty
//          tx       - registered serial output, idle high
//   Macro TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx_buffer #(
    parameter int NB_DATA  = 8,
    parameter int NB_ADDR  = 2,
    parameter int SB_TICKS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_tick,
    input  logic               wr_tx,
    input  logic [NB_DATA-1:0] data_tx,
    output logic               tx_full,
    output logic               tx_busy,
    output logic               tx
);
    localparam int DEPTH = 2 ** NB_ADDR;
    localparam int NS = $clog2(SB_TICKS > 16 ? SB_TICKS : 16);
    localparam int NN = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
    localparam logic [NS-1:0] TICK_LAST = NS'(15);
    localparam logic [NS-1:0] STOP_LAST = NS'(SB_TICKS - 1);
    localparam logic [NS-1:0] TICK_ONE = NS'(1);
    localparam logic [NN-1:0] BIT_LAST = NN'(NB_DATA - 1);
    localparam logic [NN-1:0] BIT_ONE = NN'(1);
    localparam logic [NB_ADDR-1:0] PTR_ONE = NB_ADDR'(1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par, par_n;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_ADDR-1:0] wr_ptr, rd_ptr;
    logic               full, empty, push, pop;

    state_t             state, state_n;
    logic [NS-1:0]      s_cnt, s_cnt_n;
    logic [NN-1:0]      n_cnt, n_cnt_n;
    logic [NB_DATA-1:0] b, b_n;
    logic               tx_n;

    assign push    = wr_tx & ~full;
    assign tx_full = full;
    assign tx_busy = (state != IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_tx;
    end

    // Full/empty are registered and only change on an unbalanced push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) begin
                empty <= 1'b0;
                full  <= (wr_ptr + PTR_ONE) == rd_ptr;
            end else if (pop && !push) begin
                full  <= 1'b0;
                empty <= (rd_ptr + PTR_ONE) == wr_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            b     <= '0;
            tx    <= 1'b1;
`ifdef TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s_cnt <= s_cnt_n;
            n_cnt <= n_cnt_n;
            b     <= b_n;
            tx    <= tx_n;
`ifdef TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        b_n     = b;
        pop     = 1'b0;
`ifdef TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    b_n     = mem[rd_ptr];
                    s_cnt_n = '0;
                    state_n = START;
`ifdef TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == TICK_LAST) begin
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                        state_n = DATA;
                    end else begin
                        s_cnt_n = s_cnt + TICK_ONE;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == TICK_LAST) begin
                        s_cnt_n = '0;
                        b_n     = b >> 1;
                        if (n_cnt == BIT_LAST) begin
`ifdef TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_cnt_n = n_cnt + BIT_ONE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + TICK_ONE;
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt == TICK_LAST) begin
                        s_cnt_n = '0;
                        state_n = STOP;
                    end else begin
                        s_cnt_n = s_cnt + TICK_ONE;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == STOP_LAST) begin
                        s_cnt_n = '0;
                        state_n = IDLE;
                    end else begin
                        s_cnt_n = s_cnt + TICK_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // tx follows the next state so the line changes on the same edge as the FSM.
`ifdef TX_PARITY_EN
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? b_n[0] : (state_n == PARITY) ? par_n : 1'b1;
`else
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? b_n[0] : 1'b1;
`endif
    end
endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter NB_ADDR, default 2, giving the FIFO address width; depth = 2^NB_ADDR words.
REQ-003 The block SHALL have parameter SB_TICKS, default 16, giving the stop-bit length in s_tick pulses.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 s_tick  input  1  16x-oversampled baud tick, one clk wide.
REQ-007 wr_tx  input  1  write strobe from the ALU interface FSM.
REQ-008 data_tx  input  NB_DATA  word to transmit, sampled when wr_tx=1.
REQ-009 tx_full  output  1  FIFO full; the writer SHALL NOT be accepted while high.
REQ-010 tx_busy  output  1  high while the serializer is not in IDLE or the FIFO is non-empty.
REQ-011 tx  output  1  serial line, idle high.

Function
REQ-012 The FIFO SHALL be circular, with write and read pointers of NB_ADDR bits plus a registered full flag and a registered empty flag.
REQ-013 A write SHALL occur when wr_tx=1 and tx_full=0; wr_tx with tx_full=1 SHALL be dropped without changing any state.
REQ-014 A simultaneous pop and accepted write SHALL leave the occupancy unchanged; both pointers SHALL advance and wrap modulo depth.
REQ-015 tx_full SHALL assert on the cycle after the write that fills the last slot and deassert on the cycle after the next pop.
REQ-016 The serializer FSM SHALL have the states IDLE, START, DATA, PARITY (present only under TX_PARITY_EN) and STOP.
REQ-017 IDLE: tx=1; if the FIFO is non-empty, the FSM SHALL pop the head into the shift register and enter START on the next clk.
REQ-018 START: tx=0 for 16 s_tick pulses, then the FSM SHALL go to DATA.
REQ-019 DATA: the FSM SHALL send NB_DATA bits LSB first, each for 16 s_tick pulses, using a bit counter of width clog2(NB_DATA).
REQ-020 STOP: tx=1 for SB_TICKS s_tick pulses, then the FSM SHALL return to IDLE; a non-empty FIFO starts the next frame without an extra idle bit beyond one clk.
REQ-021 The tick counter SHALL advance only on s_tick; clk cycles without s_tick SHALL hold all serializer state.
REQ-022 tx SHALL be driven from a register; no combinational path from any input to tx.
REQ-023 Latency: a write accepted at cycle N into an empty FIFO with the serializer in IDLE SHALL produce tx=0 at cycle N+2.
REQ-024 Words SHALL be transmitted in write order, with none lost or duplicated, across pointer wrap-around.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force tx=1, tx_full=0, tx_busy=0, FSM=IDLE, both pointers=0, all counters=0 and the shift register=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately and discard all FIFO contents; after release, tx SHALL stay 1 until a new write.

Configuration
REQ-027 With macro TX_PARITY_EN defined, the FSM SHALL insert state PARITY between DATA and STOP, driving the even-parity bit (XOR of the data bits) for 16 s_tick pulses.
REQ-028 Without TX_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL be synthesized.

Verification
REQ-029 s_tick held at 1, one write of 0xA5 -> tx=0 for 16 clk, then the bits 1,0,1,0,0,1,0,1 at 16 clk each, then tx=1 for 16 clk; tx_busy falls after STOP.
REQ-030 Six back-to-back writes 0x01..0x06 with depth 4 -> the first pops immediately; 0x02..0x05 fill the FIFO; tx_full=1; 0x06 dropped; the line carries 0x01..0x05 in order.
REQ-031 Continuous writing of 10 words, each issued as soon as tx_full=0 -> all 10 received in order across two pointer wraps.
REQ-032 reset pulled low during the DATA bit 3 of 0x3C with 2 words queued -> tx=1 at once, tx_full=0, tx_busy=0; nothing is transmitted after release.
REQ-033 TX_PARITY_EN defined, writes of 0x07 and 0x03 -> parity bit 1 then 0, each placed before the stop bit.
REQ-034 s_tick asserted every 4th clk, write 0x80 -> each bit lasts 64 clk; the frame totals 640 clk (parity off).
